// File: rtl/lcd_rx_monitor_if.sv
// 4-bit HD44780-style LCD bus as seen between display writer and panel.
// The writer drives every line; the panel side only listens.
interface lcd_rx_monitor_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_dat;

    modport master (
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output lcd_dat
    );

    modport slave (
        input lcd_e,
        input lcd_rs,
        input lcd_rw,
        input lcd_dat
    );
endinterface

// File: rtl/lcd_rx_monitor.sv
// Panel-side model of a 4-bit HD44780 bus: decodes nibble pairs and keeps
// a packed 2x16 shadow of the visible screen plus busy/overrun tracking.
module lcd_rx_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int EXEC_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 80000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_rx_monitor_if.slave    bus,
    output logic [255:0]       frame,
    output logic               frame_update,
    output logic [6:0]         ddram_addr,
    output logic               display_on,
    output logic               busy,
    output logic               overrun
);

    localparam int MAXC = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES
                                                       : EXEC_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        INIT8,
        NIB_HI,
        NIB_LO,
        EXEC
    } state_t;

    state_t        state;
    logic [6:0]    sync_q [SYNC_STAGES];
    logic          e_prev;
    logic [3:0]    hi_q;
    logic [3:0]    lo_q;
    logic          rs_q;
    logic          inc_q;
    logic          cg_q;
    logic [CW-1:0] cnt;

    logic       s_e;
    logic       s_rs;
    logic       s_rw;
    logic [3:0] s_dat;
    logic       strobe;
    logic [7:0] rx_byte;
    logic       win_hit;
    logic [4:0] win_pos;
    logic [7:0] bit_lo;
    logic [6:0] nxt_addr;

    assign s_e     = sync_q[SYNC_STAGES-1][6];
    assign s_rs    = sync_q[SYNC_STAGES-1][5];
    assign s_rw    = sync_q[SYNC_STAGES-1][4];
    assign s_dat   = sync_q[SYNC_STAGES-1][3:0];
    assign strobe  = e_prev && !s_e && !s_rw;
    assign rx_byte = {hi_q, lo_q};
    assign win_hit = (ddram_addr[5:4] == 2'b00) && !ddram_addr[6] ||
                     (ddram_addr[6:4] == 3'b100);
    assign win_pos = {ddram_addr[6], ddram_addr[3:0]};
    assign bit_lo  = {5'(5'd31 - win_pos), 3'b000};
    assign busy    = (cnt != '0);

    // Address step in the current entry direction, folding the two
    // 40-char DDRAM lines onto each other.
    always_comb begin
        nxt_addr = ddram_addr;
        if (inc_q) begin
            if (ddram_addr == 7'h27)      nxt_addr = 7'h40;
            else if (ddram_addr == 7'h67) nxt_addr = 7'h00;
            else                          nxt_addr = ddram_addr + 7'd1;
        end else begin
            if (ddram_addr == 7'h00)      nxt_addr = 7'h67;
            else if (ddram_addr == 7'h40) nxt_addr = 7'h27;
            else                          nxt_addr = ddram_addr - 7'd1;
        end
    end

    // Input synchroniser: all four lines travel together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_dat};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Nibble pairing, byte execution, screen shadow and busy emulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= INIT8;
            e_prev       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            rs_q         <= 1'b0;
            inc_q        <= 1'b1;
            cg_q         <= 1'b0;
            cnt          <= '0;
            frame        <= {32{8'h20}};
            frame_update <= 1'b0;
            ddram_addr   <= '0;
            display_on   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            e_prev       <= s_e;
            frame_update <= 1'b0;
            if (cnt != '0) cnt <= cnt - CW'(1);
            unique case (state)
                INIT8: begin
                    if (strobe && !s_rs && s_dat == 4'h2) state <= NIB_HI;
                end
                NIB_HI: begin
                    if (strobe) begin
                        hi_q  <= s_dat;
                        rs_q  <= s_rs;
                        state <= NIB_LO;
                    end
                end
                NIB_LO: begin
                    if (strobe) begin
                        lo_q  <= s_dat;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= NIB_HI;
                    // A strobe landing on the execute cycle is the next
                    // high nibble; keep it rather than drop it.
                    if (strobe) begin
                        hi_q  <= s_dat;
                        rs_q  <= s_rs;
                        state <= NIB_LO;
                    end
                    if (busy) overrun <= 1'b1;
                    if (!rs_q && rx_byte == 8'h01) cnt <= CW'(CLEAR_CYCLES);
                    else                           cnt <= CW'(EXEC_CYCLES);
                    if (!rs_q) begin
                        unique casez (rx_byte)
                            8'b1???????: begin
                                ddram_addr <= rx_byte[6:0];
                                cg_q       <= 1'b0;
                            end
                            8'b01??????: cg_q <= 1'b1;
                            8'b001?????: ;
                            8'b0001????: ;
                            8'b00001???: display_on <= rx_byte[2];
                            8'b000001??: inc_q <= rx_byte[1];
                            8'b0000001?: begin
                                ddram_addr <= '0;
                                cg_q       <= 1'b0;
                            end
                            8'b00000001: begin
                                frame        <= {32{8'h20}};
                                frame_update <= 1'b1;
                                ddram_addr   <= '0;
                                inc_q        <= 1'b1;
                                cg_q         <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else if (!cg_q) begin
                        if (win_hit && frame[bit_lo +: 8] != rx_byte) begin
                            frame[bit_lo +: 8] <= rx_byte;
                            frame_update       <= 1'b1;
                        end
                        ddram_addr <= nxt_addr;
                    end
                end
                default: state <= INIT8;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Directed bench for lcd_rx_monitor: a scoreboard queue of expected
// frame_update events checked by an independent monitor process.
module tb_lcd_rx_monitor;

    localparam int SYNC  = 2;
    localparam int EXEC  = 40;
    localparam int CLEAR = 400;

    typedef struct {
        logic [255:0] fr;
        logic [6:0]   addr;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] frame;
    logic         frame_update;
    logic [6:0]   ddram_addr;
    logic         display_on;
    logic         busy;
    logic         overrun;

    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    int           last_fall = 0;
    int           n;
    logic         fu_prev = 1'b0;
    logic [255:0] exp_frame;
    exp_t         q[$];

    lcd_rx_monitor_if bus ();

    lcd_rx_monitor #(
        .SYNC_STAGES  (SYNC),
        .EXEC_CYCLES  (EXEC),
        .CLEAR_CYCLES (CLEAR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .frame        (frame),
        .frame_update (frame_update),
        .ddram_addr   (ddram_addr),
        .display_on   (display_on),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Scoreboard monitor: every frame_update must match the oldest entry.
    always @(negedge clk) begin
        if (frame_update) begin
            check("upd_not_back_to_back", fu_prev, 1'b0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL upd_unexpected: got pulse at %0d want none",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("upd_frame", frame, e.fr);
                check("upd_addr", ddram_addr, e.addr);
                check("upd_latency", cyc, e.at);
            end
        end
        fu_prev <= frame_update;
    end

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge clk);
        bus.lcd_rs  = rs;
        bus.lcd_rw  = rw;
        bus.lcd_dat = d;
        bus.lcd_e   = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        last_fall = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr(input logic rs, input logic [7:0] b);
        nib(rs, 1'b0, b[7:4]);
        nib(rs, 1'b0, b[3:0]);
    endtask

    task automatic push(input logic [6:0] addr);
        exp_t e;
        e.fr   = exp_frame;
        e.addr = addr;
        e.at   = last_fall + SYNC + 2;
        q.push_back(e);
    endtask

    task automatic idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < CLEAR + 300; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        if (busy || cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got busy=%0b cnt=%0d want release",
                     busy, cnt);
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        int k;
        wr(1'b0, b);
        idle(k);
    endtask

    task automatic dat(input logic [7:0] b, input logic upd,
                       input int pos, input logic [6:0] addr);
        int k;
        wr(1'b1, b);
        if (upd) begin
            exp_frame[8*(31-pos) +: 8] = b;
            push(addr);
        end
        idle(k);
    endtask

    task automatic init_seq(output int cnt);
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b1, 4'h2);
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b0, 4'h2);
        wr(1'b0, 8'h28);
        idle(cnt);
    endtask

    initial begin
        bus.lcd_e   = 1'b0;
        bus.lcd_rs  = 1'b0;
        bus.lcd_rw  = 1'b0;
        bus.lcd_dat = 4'h0;
        exp_frame   = {32{8'h20}};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst_frame", frame, {32{8'h20}});
        check("rst_addr", ddram_addr, 7'h00);
        check("rst_disp", display_on, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_upd", frame_update, 1'b0);

        init_seq(n);
        check("init_busy_len", n, EXEC);
        check("init_frame", frame, {32{8'h20}});
        check("init_ovr", overrun, 1'b0);

        cmd(8'h0C);
        check("disp_on", display_on, 1'b1);

        cmd(8'h80);
        dat(8'h41, 1'b1, 0, 7'h01);
        check("a_addr", ddram_addr, 7'h01);

        cmd(8'h80);
        dat(8'h41, 1'b0, 0, 7'h01);
        check("same_addr", ddram_addr, 7'h01);

        cmd(8'hC0);
        for (int i = 0; i < 16; i++)
            dat(8'(8'h30 + i), 1'b1, 16 + i, 7'(7'h41 + i));
        dat(8'h40, 1'b0, 0, 7'h00);
        check("l2_addr", ddram_addr, 7'h51);
        check("l2_frame", frame, exp_frame);

        nib(1'b0, 1'b0, 4'h8);
        nib(1'b1, 1'b1, 4'h7);
        nib(1'b0, 1'b0, 4'h3);
        idle(n);
        check("rw_ignored", ddram_addr, 7'h03);

        cmd(8'h04);
        cmd(8'h80);
        dat(8'h58, 1'b1, 0, 7'h67);
        check("dec_wrap0", ddram_addr, 7'h67);
        cmd(8'hA7);
        dat(8'h11, 1'b0, 0, 7'h00);
        dat(8'h12, 1'b0, 0, 7'h00);
        check("dec_lin", ddram_addr, 7'h25);
        cmd(8'hC0);
        dat(8'h59, 1'b1, 16, 7'h27);
        check("dec_wrap40", ddram_addr, 7'h27);

        cmd(8'h06);
        cmd(8'hA7);
        dat(8'h13, 1'b0, 0, 7'h00);
        check("inc_wrap27", ddram_addr, 7'h40);
        cmd(8'hE7);
        dat(8'h14, 1'b0, 0, 7'h00);
        check("inc_wrap67", ddram_addr, 7'h00);

        cmd(8'h48);
        wr(1'b1, 8'h5A);
        idle(n);
        check("cg_busy", n, EXEC);
        check("cg_addr", ddram_addr, 7'h00);
        check("cg_frame", frame, exp_frame);
        cmd(8'h80);
        dat(8'h5B, 1'b1, 0, 7'h01);
        check("pre_ovr", overrun, 1'b0);

        wr(1'b0, 8'h01);
        exp_frame = {32{8'h20}};
        push(7'h00);
        idle(n);
        check("clr_busy_len", n, CLEAR);
        check("clr_frame", frame, {32{8'h20}});

        dat(8'h61, 1'b1, 0, 7'h01);
        wr(1'b0, 8'h01);
        exp_frame = {32{8'h20}};
        push(7'h00);
        repeat (100) @(negedge clk);
        check("clr_still_busy", busy, 1'b1);
        dat(8'h4B, 1'b1, 0, 7'h01);
        check("ovr_set", overrun, 1'b1);

        nib(1'b0, 1'b0, 4'hC);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_frame = {32{8'h20}};
        @(negedge clk);
        check("rst2_frame", frame, exp_frame);
        check("rst2_ovr", overrun, 1'b0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_disp", display_on, 1'b0);

        init_seq(n);
        nib(1'b0, 1'b0, 4'h8);
        nib(1'b0, 1'b1, 4'h2);
        nib(1'b0, 1'b0, 4'h5);
        idle(n);
        check("rst2_ddset", ddram_addr, 7'h05);
        dat(8'h77, 1'b1, 5, 7'h06);

        repeat (10) @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
Receiving end of the 4-bit HD44780-style LCD bus driven by the display writer (E/RS/RW/DAT[3:0]). It samples the bus on the system clock and decodes nibble pairs into commands and characters. It maintains a 32-character shadow of the visible 2x16 screen, packed in the same 256-bit layout the display writer consumes. It is used on-board to mirror or verify what the panel shows, and in benches as the panel model.

Parameters:
SYNC_STAGES, 2, flops in the input synchroniser on lcd_e/lcd_rs/lcd_rw/lcd_dat (minimum 1)
EXEC_CYCLES, 2000, busy duration after any executed command or data byte
CLEAR_CYCLES, 80000, busy duration after Clear Display

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
lcd_e  in  1  LCD enable strobe
lcd_rs  in  1  register select (0 = command, 1 = data)
lcd_rw  in  1  read/write (1 = read)
lcd_dat  in  4  LCD data nibble
frame  out  256  screen shadow; char pos p (0..31) at [255-8p -: 8]; pos 0-15 = line 1, pos 16-31 = line 2
frame_update  out  1  one-cycle pulse when frame changes
ddram_addr  out  7  current DDRAM address counter
display_on  out  1  display-control D bit
busy  out  1  emulated busy flag
overrun  out  1  sticky: a byte completed while busy

Behaviour:
- Reset (rst=0 at a clk edge) sets the following. frame is all 8'h20. frame_update=0, ddram_addr=0, display_on=0, busy=0, overrun=0. Entry mode is increment. State is INIT8. The synchroniser is cleared to 0. Any half-received byte is discarded, including when reset arrives mid-pair.
- Strobe: all four inputs pass through SYNC_STAGES flops. The strobe is a falling edge of synced e (previous 1, current 0). rs, rw and dat are taken from the same synced sample.
- Strobes with rw=1 are ignored completely: no state change and no nibble pairing.
- INIT8 state:
  - rs=0 with dat=3: 8-bit function set; stay in INIT8.
  - rs=0 with dat=2: go to NIB_HI (4-bit mode).
  - Any other strobe is ignored.
- NIB_HI: store the nibble as byte[7:4] along with its rs; go to NIB_LO.
- NIB_LO: form the byte {hi, dat} and go to EXEC. The rs latched with the high nibble is used.
- EXEC: a single cycle that executes the byte and returns to NIB_HI. End-to-end latency is SYNC_STAGES+2 clk edges from the raw e fall to the updated outputs.
- Command decode (rs=0), highest set bit wins:
  - 8'h01 Clear: frame set to all 8'h20, ddram_addr=0, entry mode set to increment, frame_update pulses.
  - 8'h02/03 Home: ddram_addr=0.
  - 8'h04-07 Entry mode: bit1 selects increment (1) or decrement (0). Shift bit (bit0) is ignored.
  - 8'h08-0F Display control: display_on = bit2.
  - 8'h10-1F Cursor/display shift: accepted, no effect.
  - 8'h20-3F Function set: no effect. Remains in 4-bit mode.
  - 8'h40-7F CGRAM address: enters CG mode. Subsequent data bytes are discarded and do not move ddram_addr until the next DDRAM-set, Clear or Home.
  - 8'h80-FF DDRAM set: ddram_addr = byte[6:0]; exits CG mode.
- Data decode (rs=1, not in CG mode):
  - If ddram_addr is 0x00-0x0F, write the byte to pos = addr.
  - If ddram_addr is 0x40-0x4F, write the byte to pos = 16 + (addr-0x40).
  - If the write changes the stored value, pulse frame_update. Other addresses are off-window: no write, no pulse.
  - The address then moves one step in the entry direction.
- Address wrap, increment: 0x27 -> 0x40, 0x67 -> 0x00. Decrement: 0x00 -> 0x67, 0x40 -> 0x27. Values 0x28-0x3F and 0x68-0x7F set directly by command count +/-1 linearly with 7-bit wrap.
- Busy:
  - Every executed byte loads a down-counter with EXEC_CYCLES, or CLEAR_CYCLES for 8'h01. busy = (counter != 0).
  - An ignored CG-mode data byte still loads EXEC_CYCLES.
  - If a byte reaches EXEC while busy=1, it is still executed, overrun is set, and the counter is reloaded.
  - overrun clears only on reset.
- frame_update is high for exactly one cycle per changing EXEC. It is never high in consecutive cycles.

Test Plan:
- Reset, then nibbles 3,3,3,2, then byte 8'h28 -> state NIB_HI; frame all 8'h20; busy asserted for EXEC_CYCLES after 8'h28; overrun=0.
- Init, then send 8'h80 followed by data "A" (8'h41) -> frame[255:248]=8'h41; frame_update pulses once, SYNC_STAGES+2 clocks after the last e fall; ddram_addr=0x01.
- Init, then 8'hC0 followed by 17 data bytes 8'h30..8'h40 -> positions 16-31 hold 8'h30..8'h3F; ddram_addr=0x51; the 17th byte leaves frame unchanged and gives no pulse.
- Init, then entry 8'h04 (decrement), 8'h80, data 8'h58 -> pos0=8'h58; ddram_addr=0x67. A further 8'hA7 followed by 2 data bytes wraps the address 0x27 -> 0x40? No: with decrement, 0x27 -> 0x26. Then 8'hC0 plus one data byte -> ddram_addr=0x27.
- Fill the screen, then 8'h01 -> frame all 8'h20; busy held for CLEAR_CYCLES. A data byte sent 100 clocks later -> written at pos0; overrun=1.
- Send only a high nibble, then pulse rst low for one clock, then a new full byte 8'h80 -> decoded as a DDRAM set with no corruption. Strobes with rw=1 interleaved anywhere cause no change.
